// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: data-memory request/acknowledge bus between the sequencer and memory
interface branch_sequencer_if #(parameter int W = 32);
  logic req, we, ack;
  logic [W-1:0] addr, wdata, rdata;
  modport master(output req, we, addr, wdata, input ack, rdata);
  modport slave(input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/branch_sequencer.sv
// branch_sequencer: multi-cycle next-PC controller for bmn/brz/bz/jmor/jalm/jspal
// Define BRANCH_OVF_EN to turn status 111 into bv; otherwise 111 falls through and flags illegal.
module branch_sequencer #(
  parameter int W = 32,
  parameter logic [W-1:0] RESET_PC = '0,
  parameter int LINK_REG = 31,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic instr_valid,
  input  logic [2:0] status,
  input  logic n,
  input  logic z,
  input  logic v,
  input  logic [W-1:0] reg_s,
  input  logic [W-1:0] j_diraddr,
  input  logic [W-1:0] sp,
  branch_sequencer_if.master mem,
  output logic [W-1:0] pc,
  output logic stall,
  output logic taken,
  output logic rf_we,
  output logic [4:0] rf_waddr,
  output logic [W-1:0] rf_wdata,
  output logic mem_err,
  output logic illegal
);
`ifdef BRANCH_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, RD, GAP, WR, LINK} state_t;
  state_t state, nxt;
  logic [2:0] op;
  logic [W-1:0] ptr, seq, tgt, seq_in, sc_pc, npc;
  logic [CW-1:0] cnt;
  logic act, done, tout, memop, acc, ld;
  always_comb begin
    act = state == RD || state == WR;
    done = act && mem.ack;
    tout = act && !mem.ack && cnt == CW'(TIMEOUT);
    memop = (status == 3'b001 && n) || status inside {3'b100, 3'b101, 3'b110};
    acc = state == IDLE && instr_valid;
    seq_in = pc + W'(4);
    sc_pc = status == 3'b010 && z ? reg_s :
            status == 3'b011 && z ? j_diraddr :
            status == 3'b111 && OVF && v ? j_diraddr : seq_in;
    // a timeout falls back to the sequential path; otherwise the target is fresh read data or the held one
    ld = (state == RD && done && (op == 3'b001 || op == 3'b100)) || state == LINK || (state == WR && done) || tout;
    npc = tout ? seq : state == RD ? mem.rdata : tgt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = acc && memop ? RD : IDLE;
      RD: nxt = done ? (op == 3'b110 ? GAP : op == 3'b101 ? LINK : IDLE) : tout ? IDLE : RD;
      GAP: nxt = WR;
      WR: nxt = done || tout ? IDLE : WR;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    mem.req = act;
    mem.we = state == WR;
    mem.addr = act ? ptr : '0;
    mem.wdata = state == WR ? seq : '0;
    stall = state != IDLE || (instr_valid && memop);
    rf_we = state == LINK;
    rf_waddr = rf_we ? 5'(LINK_REG) : '0;
    rf_wdata = rf_we ? seq : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      op <= '0;
      ptr <= '0;
      seq <= '0;
      tgt <= '0;
      cnt <= '0;
      taken <= 1'b0;
      mem_err <= 1'b0;
      illegal <= 1'b0;
    end else begin
      taken <= 1'b0;
      mem_err <= tout;
      illegal <= acc && !OVF && status == 3'b111;
      cnt <= act ? cnt + CW'(!mem.ack) : '0;
      if (acc) begin
        op <= status;
        ptr <= status == 3'b110 ? sp : reg_s;
        seq <= seq_in;
        if (!memop) begin
          pc <= sc_pc;
          taken <= sc_pc != seq_in;
        end
      end
      if (state == RD && done) tgt <= mem.rdata;
      if (ld) begin
        pc <= npc;
        taken <= npc != seq;
      end
    end
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: randomized transaction-level check of branch_sequencer against a memory/PC model
module tb_branch_sequencer;
  localparam int W = 32;
  localparam int TO = 15;
`ifdef BRANCH_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  logic clk = 0, rst_n = 0, instr_valid = 0, n = 0, z = 0, v = 0;
  logic [2:0] status = 0;
  logic [W-1:0] reg_s = 0, j_diraddr = 0, sp = 0, pc, rf_wdata;
  logic stall, taken, rf_we, mem_err, illegal;
  logic [4:0] rf_waddr;
  int checks = 0, errors = 0;
  logic [W-1:0] pc_m;
  logic [W-1:0] mem [logic [W-1:0]];
  branch_sequencer_if #(.W(W)) bus();
  branch_sequencer #(.W(W), .RESET_PC(32'h0), .LINK_REG(31), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .status(status),
    .n(n), .z(z), .v(v), .reg_s(reg_s), .j_diraddr(j_diraddr), .sp(sp),
    .mem(bus), .pc(pc), .stall(stall), .taken(taken), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .mem_err(mem_err), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] rd(input logic [W-1:0] a);
    if (!mem.exists(a)) mem[a] = $urandom & 32'hFFFF_FFFC;
    return mem[a];
  endfunction
  // one memory transfer; the responder acks on wait cycle dly, never if dly > TO
  task automatic xfer(input logic [W-1:0] a, input logic w, input logic [W-1:0] wd, input int dly,
                      output logic ok, output logic [W-1:0] rdv);
    ok = 0;
    rdv = '0;
    for (int k = 0; k <= TO; k++) begin
      check("req", bus.req, 1);
      check("addr", bus.addr, a);
      check("we", bus.we, w);
      if (w) check("wdata", bus.wdata, wd);
      check("stall_busy", stall, 1);
      ok = k == dly;
      bus.ack = ok;
      bus.rdata = ok && !w ? rd(a) : $urandom;
      rdv = bus.rdata;
      @(posedge clk); #1;
      bus.ack = 0;
      if (ok) begin
        if (w) mem[a] = wd;
        break;
      end
    end
  endtask
  task automatic idle();
    instr_valid = 0;
    status = 3'($urandom);
    bus.ack = 1'($urandom);
    @(posedge clk); #1;
    bus.ack = 0;
    check("idle_pc", pc, pc_m);
    check("idle_req", bus.req, 0);
    check("idle_stall", stall, 0);
  endtask
  task automatic run(input logic [2:0] s, input logic nn, input logic zz, input logic vv,
                     input logic [W-1:0] rs, input logic [W-1:0] jd, input logic [W-1:0] spv,
                     input int d1, input int d2);
    logic [W-1:0] seq, exp, a, rv, tmp;
    logic mop, ok;
    seq = pc_m + 4;
    mop = (s == 3'd1 && nn) || s inside {3'd4, 3'd5, 3'd6};
    instr_valid = 1; status = s; n = nn; z = zz; v = vv;
    reg_s = rs; j_diraddr = jd; sp = spv;
    #1 check("stall_acc", stall, mop);
    @(posedge clk); #1;
    if (!mop) begin
      exp = (s == 3'd2 && zz) ? rs : (s == 3'd3 && zz) ? jd : (s == 3'd7 && OVF && vv) ? jd : seq;
      ok = 1;
    end else begin
      a = s == 3'd6 ? spv : rs;
      xfer(a, 0, '0, d1, ok, rv);
      if (ok && s == 3'd6) begin
        check("gap_req", bus.req, 0);
        bus.ack = 1'($urandom);
        @(posedge clk); #1;
        bus.ack = 0;
        xfer(a, 1, seq, d2, ok, tmp);
      end else if (ok && s == 3'd5) begin
        check("link_we", rf_we, 1);
        check("link_idx", rf_waddr, 31);
        check("link_val", rf_wdata, seq);
        check("link_pc", pc, pc_m);
        check("link_req", bus.req, 0);
        @(posedge clk); #1;
      end
      exp = ok ? rv : seq;
    end
    check("pc", pc, exp);
    check("taken", taken, exp != seq);
    check("mem_err", mem_err, !ok);
    check("illegal", illegal, s == 3'd7 && !OVF);
    check("rf_we_end", rf_we, 0);
    check("req_end", bus.req, 0);
    pc_m = exp;
    instr_valid = 0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog pc=%h", pc);
    $fatal;
  end
  initial begin
    bus.ack = 0;
    bus.rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", pc, 0);
    check("rst_req", bus.req, 0);
    check("rst_stall", stall, 0);
    check("rst_taken", taken, 0);
    check("rst_rfwe", rf_we, 0);
    check("rst_err", mem_err, 0);
    check("rst_ill", illegal, 0);
    rst_n = 1;
    pc_m = 0;
    run(3'd2, 0, 1, 0, 32'h40, 0, 0, 0, 0);
    run(3'd2, 0, 1, 0, 32'h100, 0, 0, 0, 0);
    run(3'd3, 0, 0, 0, 0, 32'h700, 0, 0, 0);
    run(3'd2, 0, 1, 0, 32'h10, 0, 0, 0, 0);
    mem[32'h200] = 32'h800;
    run(3'd5, 0, 0, 0, 32'h200, 0, 0, 2, 0);
    run(3'd2, 0, 1, 0, 32'h20, 0, 0, 0, 0);
    mem[32'h3FC] = 32'h900;
    run(3'd6, 0, 0, 0, 0, 0, 32'h3FC, 1, 1);
    check("swap_mem", mem[32'h3FC], 32'h24);
    run(3'd4, 0, 0, 0, 32'h1100, 0, 0, 99, 0);
    run(3'd4, 0, 0, 0, 32'h1104, 0, 0, TO, 0);
    run(3'd1, 1, 0, 0, 32'h1108, 0, 0, 0, 0);
    run(3'd1, 0, 0, 0, 32'h1108, 0, 0, 0, 0);
    run(3'd7, 0, 0, 1, 0, 32'h500, 0, 0, 0);
    run(3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      logic [2:0] s;
      logic [W-1:0] rs, spv;
      int d1, d2, r;
      if ($urandom_range(0, 5) == 0) idle();
      s = 3'($urandom);
      rs = 32'h1000 + 4 * $urandom_range(0, 31);
      spv = 32'h1000 + 4 * $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) mem[s == 3'd6 ? spv : rs] = pc_m + 4;
      r = $urandom_range(0, 19);
      d1 = r < 16 ? r % 4 : r < 18 ? TO : 20;
      r = $urandom_range(0, 19);
      d2 = r < 16 ? r % 4 : r < 18 ? TO : 20;
      run(s, 1'($urandom), 1'($urandom), 1'($urandom), rs, $urandom & 32'hFFFF_FFFC, spv, d1, d2);
    end
    instr_valid = 1; status = 3'd4; reg_s = 32'h1040;
    @(posedge clk); #1;
    instr_valid = 0;
    @(posedge clk); #1;
    check("mid_req", bus.req, 1);
    #2 rst_n = 0;
    #1 check("mid_rst_req", bus.req, 0);
    check("mid_rst_pc", pc, 0);
    check("mid_rst_stall", stall, 0);
    @(posedge clk); #1;
    rst_n = 1;
    pc_m = 0;
    run(3'd2, 0, 1, 0, 32'h44, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
